// File: rtl/sipo_framer_if.sv
// ---------------------------------------------------------------------------
// sipo_framer_if
// Bundles the serial input side and the parallel output side of sipo_framer.
//
// Signals:
//   in         serial data bit                       (source -> framer)
//   in_valid   in/sof are sampled this cycle         (source -> framer)
//   sof        start of frame, qualified by in_valid (source -> framer)
//   msb_first  bit order for the next word started   (source -> framer)
//   out_ready  downstream accepts out this cycle     (sink   -> framer)
//   clr_ovr    clears the sticky overrun flag        (sink   -> framer)
//   out        assembled word in the holding register
//   out_valid  out holds an unconsumed word
//   bit_cnt    bits collected so far in the current word
//   overrun    sticky: a completed word was dropped
//   frag_err   one-cycle pulse: sof cut a partial word short
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and out is
// held stable while out_valid=1 and the word has not transferred.
// The serial side has no ready: every cycle with in_valid=1 delivers a bit.
//
// Modports: master = the side driving serial bits and out_ready,
//           slave  = the framer itself.
// ---------------------------------------------------------------------------
interface sipo_framer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in;
    logic             in_valid;
    logic             sof;
    logic             msb_first;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             frag_err;

    modport master (
        output in, in_valid, sof, msb_first, out_ready, clr_ovr,
        input  out, out_valid, bit_cnt, overrun, frag_err
    );

    modport slave (
        input  in, in_valid, sof, msb_first, out_ready, clr_ovr,
        output out, out_valid, bit_cnt, overrun, frag_err
    );
endinterface

// File: rtl/sipo_framer.sv
// ---------------------------------------------------------------------------
// sipo_framer
// Serial-in/parallel-out word assembler. Collects WIDTH bits qualified by
// in_valid into a word (MSB-first or LSB-first, chosen per word), then
// presents it on a valid/ready holding register. sof resynchronises the
// word boundary; a completed word that finds the holding register full is
// dropped and raises the sticky overrun flag.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sipo_framer_if.slave (serial input, parallel output, status)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module sipo_framer #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    sipo_framer_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             order_q,     order_d;
    logic             overrun_q,   overrun_d;
    logic             frag_q,      frag_d;

    logic             starts_word;
    logic             order_eff;
    logic             complete;
    logic             consume;
    logic             load;
    logic [WIDTH-1:0] sr_base;

    always_comb begin
        sr_d        = sr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        order_d     = order_q;
        overrun_d   = overrun_q;
        frag_d      = 1'b0;

        // A bit opens a word either at the natural boundary or when sof
        // forces one; only then is msb_first sampled.
        starts_word = bus.in_valid && (bus.sof || (cnt_q == '0));
        order_eff   = starts_word ? bus.msb_first : order_q;

        // On sof the partial word is thrown away so the new word is built
        // from a clean register rather than from leftover bits.
        sr_base     = (bus.in_valid && bus.sof) ? '0 : sr_q;

        // sof always restarts at bit 0, so it can never complete a word
        // (WIDTH >= 2).
        complete    = bus.in_valid && !bus.sof && (cnt_q == LAST_BIT);
        consume     = out_valid_q && bus.out_ready;
        load        = complete && (!out_valid_q || consume);

        if (bus.in_valid) begin
            order_d = order_eff;
            if (order_eff) begin
                sr_d = {sr_base[WIDTH-2:0], bus.in};
            end else begin
                sr_d = {bus.in, sr_base[WIDTH-1:1]};
            end

            if (bus.sof) begin
                cnt_d  = CNT_W'(1);
                frag_d = (cnt_q != '0);
            end else if (cnt_q == LAST_BIT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The completing bit is not in sr_q yet, so load from sr_d.
        if (load) begin
            out_d       = sr_d;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        // Set has priority over clear when both land on the same edge.
        if (complete && !load) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            order_q     <= 1'b1;
            overrun_q   <= 1'b0;
            frag_q      <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            order_q     <= order_d;
            overrun_q   <= overrun_d;
            frag_q      <= frag_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.frag_err  = frag_q;

endmodule

// File: tb/tb_sipo_framer.sv
// ---------------------------------------------------------------------------
// tb_sipo_framer
// Directed bench for sipo_framer at WIDTH=8. Inputs change on the falling
// edge and outputs are checked on the falling edge, half a cycle after the
// rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_sipo_framer;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sipo_framer_if #(.WIDTH(WIDTH)) bus ();

    sipo_framer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // one accepted bit; returns at the falling edge after it was sampled
    task automatic send_bit(input logic b, input logic s, input logic m);
        bus.in        = b;
        bus.sof       = s;
        bus.msb_first = m;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic m);
        for (int i = 0; i < 8; i++) begin
            send_bit(m ? w[7-i] : w[i], 1'b0, m);
        end
    endtask

    initial begin
        logic [7:0] pat;
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sof       = 1'b0;
        bus.msb_first = 1'b1;
        bus.out_ready = 1'b0;
        bus.clr_ovr   = 1'b0;

        // reset held 10 cycles with in_valid toggling
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("rst_out",       bus.out,       8'h00);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bit_cnt",   bus.bit_cnt,   0);
        check("rst_overrun",   bus.overrun,   0);
        check("rst_frag_err",  bus.frag_err,  0);
        rst = 1'b0;
        @(negedge clk);

        // MSB first: 1,1,0,0,0,0,0,1 -> C1
        bus.out_ready = 1'b1;
        pat = 8'b1100_0001;
        for (int i = 0; i < 7; i++) send_bit(pat[7-i], 1'b0, 1'b1);
        check("msb_cnt7",    bus.bit_cnt,   7);
        check("msb_early_v", bus.out_valid, 0);
        send_bit(pat[0], 1'b0, 1'b1);
        check("msb_out",     bus.out,       8'hC1);
        check("msb_valid",   bus.out_valid, 1);
        check("msb_cnt_wrap", bus.bit_cnt,  0);
        idle(1);
        check("msb_consumed", bus.out_valid, 0);

        // LSB first, same stream, msb_first toggled from bit 4 on -> 83
        for (int i = 0; i < 8; i++) send_bit(pat[7-i], 1'b0, (i >= 4));
        check("lsb_out",   bus.out,       8'h83);
        check("lsb_valid", bus.out_valid, 1);
        idle(1);

        // backpressure: A5 held, 3C dropped -> overrun
        bus.out_ready = 1'b0;
        send_word(8'hA5, 1'b1);
        check("bp_first_out", bus.out,     8'hA5);
        check("bp_no_ovr",    bus.overrun, 0);
        send_word(8'h3C, 1'b1);
        check("bp_held_out",  bus.out,       8'hA5);
        check("bp_held_v",    bus.out_valid, 1);
        check("bp_overrun",   bus.overrun,   1);
        bus.clr_ovr = 1'b1;
        idle(1);
        bus.clr_ovr = 1'b0;
        check("clr_overrun",  bus.overrun,   0);
        check("clr_keep_out", bus.out,       8'hA5);

        // simultaneous: 5A completes on the edge that consumes A5
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i == 7);
            send_bit(pat[7-i], 1'b0, 1'b1);
        end
        check("sim_out",   bus.out,       8'h5A);
        check("sim_valid", bus.out_valid, 1);
        check("sim_no_ovr", bus.overrun,  0);
        idle(1);
        check("sim_drained", bus.out_valid, 0);

        // fragment: 3 bits, then sof + 7 bits -> 1_0110011 = B3
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        check("frag_cnt3", bus.bit_cnt,  3);
        check("frag_idle", bus.frag_err, 0);
        send_bit(1'b1, 1'b1, 1'b1);
        check("frag_pulse", bus.frag_err, 1);
        check("frag_cnt1",  bus.bit_cnt,  1);
        pat = 8'b0011_0011;
        for (int i = 0; i < 7; i++) begin
            send_bit(pat[6-i], 1'b0, 1'b1);
            if (i == 0) check("frag_one_cycle", bus.frag_err, 0);
        end
        check("frag_out",   bus.out,       8'hB3);
        check("frag_valid", bus.out_valid, 1);

        // reset mid-word with a held word, then sof at bit_cnt=0 -> 3C
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b1);
        check("rmw_cnt5", bus.bit_cnt, 5);
        rst = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("rmw_cnt0",  bus.bit_cnt,   0);
        check("rmw_valid", bus.out_valid, 0);
        check("rmw_out",   bus.out,       8'h00);
        pat = 8'h3C;
        send_bit(pat[7], 1'b1, 1'b1);
        check("rmw_sof_clean", bus.frag_err, 0);
        for (int i = 6; i >= 0; i--) send_bit(pat[i], 1'b0, 1'b1);
        check("rmw_word",  bus.out,       8'h3C);
        check("rmw_word_v", bus.out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
